// File: rtl/apb_master_ctrl.sv
// APB initiator: turns one outstanding cmd/rsp request into an APB SETUP + ACCESS transfer.
// Latency: command accepted at edge N, rsp_valid after edge N+2, plus one cycle per PREADY=0 wait state.
// Backpressure: cmd_ready is low from accept until completion; cmd_valid is ignored while cmd_ready=0.
//
// Ports:
//   PCLK, PRESET                     clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata local command request
//   rsp_valid/rdata/err              one-cycle completion pulse with read data and error
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA APB request outputs (all registered)
//   PREADY/PRDATA/PSLVERR            APB slave response inputs
//
// Optional: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase that waits
// more than TIMEOUT_CYCLES PREADY=0 cycles (completes with rsp_err=1, rsp_rdata=0).
module apb_master_ctrl #(
    parameter int AWIDTH         = 8,
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic              r_cmd_ready, w_cmd_ready_nxt;
    logic              r_psel,      w_psel_nxt;
    logic              r_penable,   w_penable_nxt;
    logic              r_pwrite,    w_pwrite_nxt;
    logic [AWIDTH-1:0] r_paddr,     w_paddr_nxt;
    logic [DWIDTH-1:0] r_pwdata,    w_pwdata_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DWIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;
    logic              w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait_cnt;

    // Counter value equals the number of PREADY=0 ACCESS cycles seen so far.
    assign w_timeout = (r_state == ACCESS) && (r_wait_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == ACCESS && !PREADY && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            // cmd_ready is already high in the first cycle after reset releases.
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;           // single-cycle pulse
        w_rsp_rdata_nxt = r_rsp_rdata;    // holds until next completion
        w_rsp_err_nxt   = 1'b0;           // only meaningful alongside rsp_valid

        case (r_state)
            IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_pwrite_nxt    = cmd_write;
                    w_paddr_nxt     = cmd_addr;
                    w_pwdata_nxt    = cmd_wdata;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = SETUP;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                // A real PREADY wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (w_timeout) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
                w_cmd_ready_nxt = 1'b1;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    apb_master_ctrl #(
        .AWIDTH         (AW),
        .DWIDTH         (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    // One full transfer, checked cycle by cycle (all sampling on the falling edge).
    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge PCLK);
        chk({p, "_idle_rdy"}, cmd_ready, 1);
        chk({p, "_idle_psel"}, PSEL, 0);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge PCLK);
        // Scramble the command bus: the latched APB request must not follow it.
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.wr;
        chk({p, "_setup_psel"}, PSEL, 1);
        chk({p, "_setup_pen"}, PENABLE, 0);
        chk({p, "_setup_rdy"}, cmd_ready, 0);
        chk({p, "_setup_paddr"}, PADDR, v.addr);
        chk({p, "_setup_pwrite"}, PWRITE, v.wr);
        chk({p, "_setup_pwdata"}, PWDATA, v.wdata);
        chk({p, "_setup_rv"}, rsp_valid, 0);
        for (int i = 0; i <= v.waits; i++) begin
            @(negedge PCLK);
            chk($sformatf("%s_acc%0d_psel", p, i), PSEL, 1);
            chk($sformatf("%s_acc%0d_pen", p, i), PENABLE, 1);
            chk($sformatf("%s_acc%0d_paddr", p, i), PADDR, v.addr);
            chk($sformatf("%s_acc%0d_pwdata", p, i), PWDATA, v.wdata);
            chk($sformatf("%s_acc%0d_rv", p, i), rsp_valid, 0);
            if (i == v.waits) begin
                PREADY  = 1'b1;
                PRDATA  = v.prdata;
                PSLVERR = v.slverr;
            end else begin
                // Junk while not ready must be ignored.
                PREADY  = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
                PSLVERR = 1'b1;
            end
        end
        @(negedge PCLK);
        chk({p, "_done_rv"}, rsp_valid, 1);
        chk({p, "_done_err"}, rsp_err, v.exp_err);
        chk({p, "_done_rdata"}, rsp_rdata, v.exp_rdata);
        chk({p, "_done_psel"}, PSEL, 0);
        chk({p, "_done_pen"}, PENABLE, 0);
        chk({p, "_done_rdy"}, cmd_ready, 1);
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'h5555_AAAA;
        @(negedge PCLK);
        chk({p, "_post_rv"}, rsp_valid, 0);
        chk({p, "_post_err"}, rsp_err, 0);
        chk({p, "_post_rdata_hold"}, rsp_rdata, v.exp_rdata);
        chk({p, "_post_rdy"}, cmd_ready, 1);
        PSLVERR = 1'b0;
    endtask

    // Back-to-back expected timeline, one entry per falling edge after the first accept.
    logic       bb_psel [7] = '{1, 1, 0, 1, 1, 0, 0};
    logic       bb_pen  [7] = '{0, 1, 0, 0, 1, 0, 0};
    logic       bb_rv   [7] = '{0, 0, 1, 0, 0, 1, 0};
    logic       bb_rdy  [7] = '{0, 0, 1, 0, 0, 1, 1};
    logic [7:0] bb_addr [7] = '{8'h21, 8'h21, 8'h21, 8'h3C, 8'h3C, 8'h3C, 8'h3C};

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;

        //               wr    addr   wdata          waits prdata         slverr exp_rdata      exp_err
        vecs[0] = '{1'b1, 8'h02, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 8'h03, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 8'h0F, 32'h0000_0000, 0, 32'h0BAD_0BAD, 1'b1, 32'h0BAD_0BAD, 1'b1};
        vecs[3] = '{1'b0, 8'h10, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 2, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 32'h0000_0000, 1, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0};

        // Reset state
        repeat (2) @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_pen", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rdata", rsp_rdata, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_rel_rdy", cmd_ready, 1);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Back-to-back with cmd_valid held high
        @(negedge PCLK);
        PREADY    = 1'b1;
        PRDATA    = 32'h9999_0042;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h21;
        cmd_wdata = 32'h1111_1111;
        for (int k = 0; k < 7; k++) begin
            @(negedge PCLK);
            if (k == 0) begin
                // Second command presented while the first is in flight.
                cmd_write = 1'b0;
                cmd_addr  = 8'h3C;
                cmd_wdata = 32'h2222_2222;
            end
            if (k == 3) cmd_valid = 1'b0;
            chk($sformatf("bb%0d_psel", k), PSEL, bb_psel[k]);
            chk($sformatf("bb%0d_pen", k), PENABLE, bb_pen[k]);
            chk($sformatf("bb%0d_rv", k), rsp_valid, bb_rv[k]);
            chk($sformatf("bb%0d_rdy", k), cmd_ready, bb_rdy[k]);
            chk($sformatf("bb%0d_paddr", k), PADDR, bb_addr[k]);
            if (k == 2) chk("bb_wr_rdata", rsp_rdata, 32'h0);
            if (k == 5) chk("bb_rd_rdata", rsp_rdata, 32'h9999_0042);
        end
        PREADY = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        begin
            int n_acc;
            bit hit;
            n_acc = 0;
            hit   = 1'b0;
            @(negedge PCLK);
            PRDATA    = 32'hABCD_EF01;
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 8'h44;
            @(negedge PCLK);
            cmd_valid = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge PCLK);
                if (rsp_valid) begin
                    hit = 1'b1;
                    break;
                end
                if (PENABLE) n_acc++;
            end
            chk("to_hit", hit, 1);
            chk("to_access_cycles", n_acc, 5);
            chk("to_err", rsp_err, 1);
            chk("to_rdata", rsp_rdata, 0);
            chk("to_psel", PSEL, 0);
            chk("to_pen", PENABLE, 0);
        end
`endif

        // Reset in the middle of ACCESS
        @(negedge PCLK);
        PREADY    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h55;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mr_acc_psel", PSEL, 1);
        chk("mr_acc_pen", PENABLE, 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mr_psel", PSEL, 0);
        chk("mr_pen", PENABLE, 0);
        chk("mr_rv", rsp_valid, 0);
        chk("mr_paddr", PADDR, 0);
        PRESET = 1'b0;
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("mr_rel_rdy", cmd_ready, 1);
        chk("mr_rel_rv", rsp_valid, 0);
        chk("mr_rel_psel", PSEL, 0);
        PREADY = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
